// File: rtl/bch_encode_sched.sv
// Round-robin scheduler sharing one bch_encode instance among REQ frame sources.
// P packs the code geometry: P[31:16] = data bits per frame, P[15:0] = ECC bits.
module bch_encode_sched #(
    parameter logic [31:0] P    = 32'h000B_0004,
    parameter int          BITS = 1,
    parameter int          REQ  = 4,
    localparam int         IDW  = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [REQ-1:0]      req,
    input  logic [REQ*BITS-1:0] req_data,
    output logic [REQ-1:0]      gnt,
    output logic [REQ-1:0]      req_ready,
    output logic                enc_start,
    output logic                enc_accepted,
    output logic [BITS-1:0]     enc_data_in,
    input  logic [BITS-1:0]     enc_data_out,
    input  logic                enc_first,
    input  logic                enc_last,
    input  logic                enc_busy,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic [BITS-1:0]     out_data,
    output logic [IDW-1:0]      out_id,
    input  logic                out_ready,
    output logic                frame_done
);
    localparam int DATA_CYCLES = (int'(P[31:16]) + BITS - 1) / BITS;
    localparam int CW          = $clog2(DATA_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, DRAIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [CW-1:0]  cnt;
    logic           advance;
    logic           grant_now;
    logic           last_xfer;

    // Output slot is free or draining this cycle, so the encoder may step.
    assign advance   = out_ready || !out_valid;
    assign grant_now = (state == IDLE) && (|req) && !enc_busy;
    assign last_xfer = (state == DRAIN) && out_valid && out_ready && enc_last;

    // Scan downward so the lowest offset from ptr is assigned last and wins.
    always_comb begin
        winner = ptr;
        for (int i = REQ - 1; i >= 0; i--) begin
            if (req[IDW'((int'(ptr) + i) % REQ)]) begin
                winner = IDW'((int'(ptr) + i) % REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (grant_now) state_nxt = START;
            START: if (advance) state_nxt = (DATA_CYCLES == 1) ? DRAIN : DATA;
            DATA:  if (advance && cnt == CW'(1)) state_nxt = DRAIN;
            DRAIN: if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        enc_start    = 1'b0;
        enc_accepted = 1'b1;
        enc_data_in  = '0;
        req_ready    = '0;
        case (state)
            START, DATA: begin
                enc_start    = (state == START);
                enc_accepted = advance;
                enc_data_in  = req_data[int'(out_id)*BITS +: BITS];
                req_ready    = gnt & {REQ{advance}};
            end
            DRAIN: enc_accepted = advance;
            default: ;
        endcase
    end

    // Registered control: grant, pointer, word counter and output qualifiers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt        <= '0;
            out_id     <= '0;
            ptr        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_xfer;
            if (grant_now) begin
                gnt    <= REQ'(1) << winner;
                out_id <= winner;
            end
            if (last_xfer) begin
                gnt <= '0;
                ptr <= IDW'((int'(out_id) + 1) % REQ);
            end
            if (state == START && advance) begin
                cnt <= CW'(DATA_CYCLES - 1);
            end else if (state == DATA && advance) begin
                cnt <= cnt - CW'(1);
            end
            if ((state == START || state == DATA) && advance) begin
                out_valid <= 1'b1;
            end else if (state == DRAIN && advance && !last_xfer) begin
                out_valid <= 1'b1;
            end else begin
                out_valid <= out_valid && !out_ready;
            end
        end
    end

    assign out_data  = enc_data_out;
    assign out_first = out_valid & enc_first;
    assign out_last  = out_valid & enc_last;

endmodule
